mem_stage: RTL and testbench



---
 rtl/mem_stage_if.sv | 17 +
 rtl/mem_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response bus between the memory stage and the data memory.
//   req/we/addr/wdata/be : request driven by the memory stage, held until gnt
//   gnt                  : request accepted this cycle
//   rvalid/rdata         : load data returned by the memory
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: takes the EX/MEM register, performs loads/stores
// over the dmem bus, and produces the registered MEM/WB register.
//   clk, reset_n            : clock, asynchronous active-low reset
//   execute_enable_out, EX_MEM_* : EX/MEM pipeline register (held while mem_stall)
//   dmem                    : data-memory bus (master side)
//   mem_stall               : combinational stall to earlier stages
//   MEM_WB_*, memory_enable_out : MEM/WB pipeline register
//   mem_misaligned, mem_bus_error : registered one-cycle error pulses
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        execute_enable_out,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [2:0]  EX_MEM_Funct3,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic [31:0] MEM_WB_Result,
  output logic [4:0]  MEM_WB_Rd,
  output logic        MEM_WB_RegWrite,
  output logic        memory_enable_out,
  output logic        mem_misaligned,
  output logic        mem_bus_error
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [4:0]        rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wb_result_q, wb_result_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              wb_valid_q, wb_valid_d;
  logic              misaligned_q, misaligned_d;
  logic              bus_error_q, bus_error_d;

  // Decode of the incoming EX/MEM instruction
  logic        mem_op;
  logic        size_b;
  logic        size_h;
  logic [1:0]  off_in;
  logic        misaligned_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  assign mem_op = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign off_in = EX_MEM_ALUResult[1:0];
  assign size_b = (EX_MEM_Funct3 == 3'b000) || (EX_MEM_Funct3 == 3'b100);
  assign size_h = (EX_MEM_Funct3 == 3'b001) || (EX_MEM_Funct3 == 3'b101);
  assign misaligned_in = ((EX_MEM_Funct3[1:0] == 2'b01) && off_in[0]) ||
                         ((EX_MEM_Funct3[1:0] == 2'b10) && (off_in != 2'b00));

  // Byte enables and lane-replicated store data; every other funct3 is a word
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = EX_MEM_WriteData;
    if (size_b) begin
      be_in    = 4'b0001 << off_in;
      wdata_in = {4{EX_MEM_WriteData[7:0]}};
    end else if (size_h) begin
      be_in    = 4'b0011 << off_in;
      wdata_in = {2{EX_MEM_WriteData[15:0]}};
    end
  end

  // Load data: shift the addressed byte/half down, then extend per funct3
  logic [31:0] rdata_sh;
  logic [31:0] load_data;

  assign rdata_sh = dmem.rdata >> {off_q, 3'b000};

  always_comb begin
    unique case (funct3_q)
      3'b000:  load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b100:  load_data = {24'd0, rdata_sh[7:0]};
      3'b001:  load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  load_data = {16'd0, rdata_sh[15:0]};
      default: load_data = dmem.rdata;
    endcase
  end

  // Completion beats the timeout when both land on the last allowed cycle;
  // a load grant is not a completion, it only moves on to RESP.
  logic complete;
  logic timeout;
  logic accept_mem;

  assign complete   = ((state_q == S_REQ) && dmem.gnt && we_q) ||
                      ((state_q == S_RESP) && dmem.rvalid);
  assign timeout    = (state_q != S_IDLE) && (cnt_q == CNT_LAST) && !complete;
  assign accept_mem = (state_q == S_IDLE) && execute_enable_out && mem_op && !misaligned_in;
  assign mem_stall  = accept_mem || ((state_q != S_IDLE) && !complete && !timeout);

  // Next-state and next-register logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    wb_result_d   = wb_result_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = 1'b0;
    wb_valid_d    = 1'b0;
    misaligned_d  = 1'b0;
    bus_error_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (execute_enable_out) begin
          if (!mem_op) begin
            wb_valid_d    = 1'b1;
            wb_result_d   = EX_MEM_ALUResult;
            wb_rd_d       = EX_MEM_Rd;
            wb_regwrite_d = EX_MEM_RegWrite;
          end else if (misaligned_in) begin
            misaligned_d = 1'b1;
          end else begin
            // A set MemRead wins when both MemRead and MemWrite are set
            req_d      = 1'b1;
            we_d       = !EX_MEM_MemRead;
            addr_d     = {EX_MEM_ALUResult[31:2], 2'b00};
            wdata_d    = wdata_in;
            be_d       = be_in;
            rd_d       = EX_MEM_Rd;
            regwrite_d = EX_MEM_RegWrite;
            funct3_d   = EX_MEM_Funct3;
            off_d      = off_in;
            cnt_d      = '0;
            state_d    = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout) begin
          req_d       = 1'b0;
          bus_error_d = 1'b1;
          state_d     = S_IDLE;
        end else if (dmem.gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            wb_valid_d  = 1'b1;
            wb_result_d = {addr_q[31:2], off_q};
            wb_rd_d     = rd_q;
            state_d     = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.rvalid) begin
          wb_valid_d    = 1'b1;
          wb_result_d   = load_data;
          wb_rd_d       = rd_q;
          wb_regwrite_d = regwrite_q;
          state_d       = S_IDLE;
        end else if (timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      wb_result_q   <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_valid_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      wb_result_q   <= wb_result_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_valid_q    <= wb_valid_d;
      misaligned_q  <= misaligned_d;
      bus_error_q   <= bus_error_d;
    end
  end

  assign dmem.req          = req_q;
  assign dmem.we           = we_q;
  assign dmem.addr         = addr_q;
  assign dmem.wdata        = wdata_q;
  assign dmem.be           = be_q;
  assign MEM_WB_Result     = wb_result_q;
  assign MEM_WB_Rd         = wb_rd_q;
  assign MEM_WB_RegWrite   = wb_regwrite_q;
  assign memory_enable_out = wb_valid_q;
  assign mem_misaligned    = misaligned_q;
  assign mem_bus_error     = bus_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage with a behavioural memory and reference model.
module tb_mem_stage;
  localparam int TO = 6;
  localparam int K_RET = 0;
  localparam int K_MIS = 1;
  localparam int K_BERR = 2;

  logic        clk;
  logic        reset_n;
  logic        execute_enable_out;
  logic [31:0] EX_MEM_ALUResult;
  logic [31:0] EX_MEM_WriteData;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_RegWrite;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic [2:0]  EX_MEM_Funct3;
  logic        mem_stall;
  logic [31:0] MEM_WB_Result;
  logic [4:0]  MEM_WB_Rd;
  logic        MEM_WB_RegWrite;
  logic        memory_enable_out;
  logic        mem_misaligned;
  logic        mem_bus_error;

  mem_stage_if dmem_bus ();

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .execute_enable_out (execute_enable_out),
    .EX_MEM_ALUResult   (EX_MEM_ALUResult),
    .EX_MEM_WriteData   (EX_MEM_WriteData),
    .EX_MEM_Rd          (EX_MEM_Rd),
    .EX_MEM_RegWrite    (EX_MEM_RegWrite),
    .EX_MEM_MemRead     (EX_MEM_MemRead),
    .EX_MEM_MemWrite    (EX_MEM_MemWrite),
    .EX_MEM_Funct3      (EX_MEM_Funct3),
    .dmem               (dmem_bus),
    .mem_stall          (mem_stall),
    .MEM_WB_Result      (MEM_WB_Result),
    .MEM_WB_Rd          (MEM_WB_Rd),
    .MEM_WB_RegWrite    (MEM_WB_RegWrite),
    .memory_enable_out  (memory_enable_out),
    .mem_misaligned     (mem_misaligned),
    .mem_bus_error      (mem_bus_error)
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] res;
    bit          chk;
    logic [4:0]  rd;
    bit          rw;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int g;
    int r;
  } plan_t;

  exp_t        exp_q[$];
  req_t        req_q[$];
  plan_t       plan_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] slave_mem[64];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          stray_rv = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w,
                                           input logic [1:0] off);
    logic [31:0] v;
    v = w >> (8 * int'(off));
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return {24'd0, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'd0, v[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory responder: latencies come from the plan queue written alongside each request
  initial begin : slave
    int phase;
    int g;
    int r;
    int idx;
    plan_t p;
    phase = 0; g = 0; r = 0; idx = 0;
    dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      dmem_bus.gnt = 1'b0;
      dmem_bus.rvalid = 1'b0;
      dmem_bus.rdata = $urandom;
      if (!reset_n || mem_bus_error) phase = 0;
      if (phase == 0 && dmem_bus.req && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        g = p.g; r = p.r; phase = 1;
      end
      if (phase == 1) begin
        if (!dmem_bus.req) phase = 0;
        else if (g == 0) begin
          dmem_bus.gnt = 1'b1;
          idx = int'(dmem_bus.addr[7:2]);
          if (dmem_bus.we) begin
            for (int i = 0; i < 4; i++)
              if (dmem_bus.be[i]) slave_mem[idx][8*i +: 8] = dmem_bus.wdata[8*i +: 8];
            phase = 0;
          end else phase = 2;
        end else g--;
      end else if (phase == 2) begin
        if (r == 0) begin
          dmem_bus.rvalid = 1'b1;
          dmem_bus.rdata = slave_mem[idx];
          phase = 0;
        end else r--;
      end else if (!dmem_bus.req && $urandom_range(0, 5) == 0) begin
        dmem_bus.gnt = 1'b1;
      end
      if (phase != 2 && !dmem_bus.rvalid && (stray_rv || $urandom_range(0, 5) == 0))
        dmem_bus.rvalid = 1'b1;
      stray_rv = 1'b0;
    end
  end

  // Request monitor: every cycle of an outstanding request must match the expected one
  initial begin : req_mon
    bit   active;
    req_t q;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) active = 1'b0;
      else if (dmem_bus.req) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got req=1 addr=0x%08h, expected no request", dmem_bus.addr);
        end else begin
          q = req_q[0];
          chk("req_we", 32'(dmem_bus.we), 32'(q.we));
          chk("req_addr", dmem_bus.addr, q.addr);
          if (q.we) begin
            chk("req_be", 32'(dmem_bus.be), 32'(q.be));
            chk("req_wdata", dmem_bus.wdata, q.wdata);
          end
        end
        active = 1'b1;
      end else if (active) begin
        if (req_q.size() > 0) void'(req_q.pop_front());
        active = 1'b0;
      end
    end
  end

  // MEM/WB monitor: pops the scoreboard whenever the stage retires or flags an error
  initial begin : wb_mon
    exp_t       e;
    logic [2:0] flags;
    logic [2:0] ef;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (!memory_enable_out) chk("bubble_regwrite", 32'(MEM_WB_RegWrite), 32'd0);
        flags = {memory_enable_out, mem_misaligned, mem_bus_error};
        if (flags != 3'b000) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got flags=%b, expected nothing pending", flags);
          end else begin
            e = exp_q.pop_front();
            ef = (e.kind == K_RET) ? 3'b100 : (e.kind == K_MIS) ? 3'b010 : 3'b001;
            chk("wb_flags", 32'(flags), 32'(ef));
            chk("wb_cycle", cyc, e.cyc);
            if (e.kind == K_RET) begin
              chk("wb_regwrite", 32'(MEM_WB_RegWrite), 32'(e.rw));
              if (e.chk) begin
                chk("wb_rd", 32'(MEM_WB_Rd), 32'(e.rd));
                chk("wb_result", MEM_WB_Result, e.res);
              end
            end
          end
        end
      end
    end
  end

  task automatic present(input bit v, input bit mr, input bit mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input bit rw);
    execute_enable_out = v;
    EX_MEM_MemRead = mr;
    EX_MEM_MemWrite = mw;
    EX_MEM_Funct3 = f3;
    EX_MEM_ALUResult = a;
    EX_MEM_WriteData = d;
    EX_MEM_Rd = rd;
    EX_MEM_RegWrite = rw;
  endtask

  // Presents one EX/MEM instruction, pushes its expectations, holds it while stalled
  task automatic issue(input bit v, input bit mr, input bit mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input bit rw, input int g, input int r);
    int          n;
    int          nb;
    int          stalls;
    int          exp_stall;
    int          idx;
    logic [1:0]  off;
    exp_t        e;
    req_t        q;
    plan_t       p;
    bit          done;
    present(v, mr, mw, f3, a, d, rd, rw);
    n = cyc;
    off = a[1:0];
    nb = nbytes(f3);
    idx = int'(a[7:2]);
    exp_stall = 0;
    e.kind = K_RET; e.cyc = n + 1; e.res = a; e.chk = 1'b1; e.rd = rd; e.rw = rw;
    if (v && !(mr || mw)) exp_q.push_back(e);
    else if (v) begin
      if ((nb == 2 && off[0]) || (nb == 4 && off != 2'b00)) begin
        e.kind = K_MIS;
        exp_q.push_back(e);
      end else begin
        q.we = !mr;
        q.addr = {a[31:2], 2'b00};
        q.be = 4'(((1 << nb) - 1) << off);
        q.wdata = (nb == 1) ? {4{d[7:0]}} : (nb == 2) ? {2{d[15:0]}} : d;
        req_q.push_back(q);
        p.g = g; p.r = r;
        plan_q.push_back(p);
        if (!mr) begin
          done = (g <= TO - 1);
          if (done) begin
            for (int i = 0; i < 4; i++)
              if (q.be[i]) ref_mem[idx][8*i +: 8] = q.wdata[8*i +: 8];
            e.cyc = n + 2 + g; e.chk = 1'b0; e.rw = 1'b0; exp_stall = 1 + g;
          end
        end else begin
          done = (g < TO - 1) && (g + 1 + r <= TO - 1);
          if (done) begin
            e.res = load_ext(f3, ref_mem[idx], off);
            e.cyc = n + 3 + g + r; exp_stall = 2 + g + r;
          end
        end
        if (!done) begin
          e.kind = K_BERR; e.cyc = n + TO + 1; exp_stall = TO;
        end
        exp_q.push_back(e);
      end
    end
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!mem_stall) break;
      stalls++;
      if (stalls > 60) begin
        checks++; errors++;
        $display("FAIL stall_bound: got stall for %0d cycles, expected release", stalls);
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("stall_cycles", stalls, exp_stall);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int          kind;
    logic [2:0]  f3;
    logic [31:0] a;
    int          nb;
    int          g;
    int          r;
    logic [2:0]  ld_f3[5];
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'h0;
      slave_mem[i] = 32'h0;
    end
    reset_n = 1'b0;
    present(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_bus.req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_valid", 32'(memory_enable_out), 32'd0);
    chk("rst_result", MEM_WB_Result, 32'd0);
    chk("rst_rd", 32'(MEM_WB_Rd), 32'd0);
    chk("rst_errs", 32'({mem_misaligned, mem_bus_error, MEM_WB_RegWrite}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    issue(1, 0, 0, 3'b010, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0);
    issue(1, 0, 1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd3, 1, 0, 0);
    issue(1, 0, 1, 3'b010, 32'h0000_0200, 32'h8001_0000, 5'd1, 0, 1, 0);
    issue(1, 1, 0, 3'b001, 32'h0000_0202, 32'h0, 5'd9, 1, 0, 3);
    issue(1, 1, 0, 3'b101, 32'h0000_0202, 32'h0, 5'd10, 1, 0, 3);
    issue(1, 1, 0, 3'b010, 32'h0000_0006, 32'h0, 5'd11, 1, 0, 0);
    issue(1, 0, 1, 3'b010, 32'h0000_0010, 32'h1111_2222, 5'd2, 0, 20, 0);
    issue(1, 0, 1, 3'b010, 32'h0000_0014, 32'h3333_4444, 5'd2, 0, TO - 1, 0);
    issue(1, 1, 0, 3'b010, 32'h0000_0014, 32'h0, 5'd12, 1, TO - 1, 0);
    issue(1, 1, 0, 3'b010, 32'h0000_0014, 32'h0, 5'd13, 1, 0, TO - 2);
    issue(1, 1, 1, 3'b100, 32'h0000_0017, 32'h0, 5'd14, 1, 0, 0);

    // Reset while the load is waiting in RESP
    present(1, 1, 0, 3'b010, 32'h0000_0040, 32'h0, 5'd7, 1);
    req_q.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0, be: 4'hF});
    plan_q.push_back('{g: 0, r: 40});
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    execute_enable_out = 1'b0;
    #1;
    chk("rst_resp_req", 32'(dmem_bus.req), 32'd0);
    chk("rst_resp_valid", 32'(memory_enable_out), 32'd0);
    chk("rst_resp_stall", 32'(mem_stall), 32'd0);
    chk("rst_resp_result", MEM_WB_Result, 32'd0);
    req_q.delete();
    plan_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    stray_rv = 1'b1;
    @(posedge clk); #1;
    issue(0, 1, 0, 3'b010, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    chk("stray_rvalid_ignored", 32'(memory_enable_out), 32'd0);
    issue(1, 1, 0, 3'b010, 32'h0000_0200, 32'h0, 5'd8, 1, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      kind = $urandom_range(0, 7);
      a = $urandom;
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 2);
      r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : $urandom_range(0, 2);
      if (kind == 0) begin
        issue(0, 1'($urandom), 1'($urandom), 3'($urandom), a, $urandom, 5'($urandom),
              1'($urandom), 0, 0);
      end else if (kind <= 2) begin
        issue(1, 0, 0, 3'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 0, 0);
      end else begin
        if (kind <= 5) f3 = ld_f3[$urandom_range(0, 4)];
        else f3 = 3'($urandom_range(0, 2));
        nb = nbytes(f3);
        if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
        issue(1, kind <= 5, (kind > 5) || ($urandom_range(0, 7) == 0), f3, a, $urandom,
              5'($urandom), 1'($urandom), g, r);
      end
    end

    issue(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
